store_serializer: RTL and testbench
===================================

# store_serializer

Store-side narrowing unit for the MIPS datapath, the write-direction counterpart of the load-side sign/zero extension path. It accepts one 32-bit store request (sb/sh/sw) from the memory stage and splits it into big-endian bytes, one per cycle, on an 8-bit memory write port. It checks alignment and reports completion or error per request.

## Interface
- ADDR_W, 32, byte address width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request
- req_addr  in  ADDR_W  byte address of store
- req_data  in  32  register value to store
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- mem_valid  out  1  byte write presented
- mem_ready  in  1  memory accepts byte
- mem_addr  out  ADDR_W  byte write address
- mem_wdata  out  8  byte write data
- done  out  1  one-cycle completion pulse
- err  out  1  valid only with done; 1 = request rejected, no bytes written

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, SEND, RESP.
- IDLE: req_ready=1. On req_valid & req_ready, capture addr, data, size:
  - illegal size (11), halfword with addr[0]=1, or word with addr[1:0]!=00 -> RESP with err=1, no mem traffic.
  - else byte count N = 1/2/4 for size 00/01/10, byte index k=0 -> SEND.
- SEND: mem_valid=1, mem_addr = captured addr + k, mem_wdata = big-endian byte k of the low N bytes of data:
  - byte: data[7:0].
  - half: k0 data[15:8], k1 data[7:0].
  - word: k0 data[31:24], k1 [23:16], k2 [15:8], k3 [7:0].
  - On mem_ready: if k=N-1 -> RESP with err=0, else k=k+1.
  - Without mem_ready, mem_addr/mem_wdata stay stable and mem_valid stays high.
- RESP: done=1 for exactly one cycle, err as decided -> IDLE.
- req_* changes after capture are ignored. The address adds modulo 2^ADDR_W; wrap is irrelevant given alignment.
- Upper data bits beyond N bytes are ignored (sb uses only data[7:0]).

## Timing
- Reset: state IDLE, req_ready=1, mem_valid=0, mem_addr=0, mem_wdata=0, done=0, err=0, k=0.
- Accept at edge T. First mem_valid in cycle T+1.
- With mem_ready tied high, bytes are written in cycles T+1..T+N. done is in cycle T+N+1 and req_ready is 0 throughout. req_ready returns to 1 in cycle T+N+2.
- Each mem_ready=0 cycle in SEND adds one cycle of latency.
- Error path: done=err=1 in cycle T+1, req_ready=1 in cycle T+2.
- req_ready is 0 in SEND and RESP. Back-to-back requests are not accepted in the done cycle.
- Asserting rst_n low mid-store abandons it immediately: outputs go to reset values asynchronously, no done.
- All outputs are registered.

## Structure
- The shared package mips_pkg holds:
  - the size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10;
  - the state typedef;
  - a function giving the byte count from the size. The load-side extension logic reuses the size constants.
- No sub-module. The byte-lane mux and index counter are inline; a 2-bit k is sufficient.

## Test plan
- sb, addr 0x1003, data 0xDEADBEEF, mem_ready=1 -> one write {0x1003, 0xEF}, done=1, err=0 at T+2.
- sh, addr 0x2002, data 0x12345678 -> writes {0x2002,0x56}, {0x2003,0x78}, done at T+3.
- sw, addr 0x3000, data 0xCAFEF00D, mem_ready low on the 2nd byte for 3 cycles -> {0x3000,0xCA} {0x3001,0xFE} {0x3002,0xF0} {0x3003,0x0D}. Address and data are held during the stall, and done comes at T+8.
- Error cases, each -> done=err=1 at T+1, mem_valid never high:
  - sh at 0x2001;
  - sw at 0x3002;
  - size 11.
- rst_n low during the 3rd byte of a sw -> mem_valid=0 at once, no done. After release, req_ready=1 and a new sb completes normally.
- req_data changed the cycle after accept -> written bytes match the captured value.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared across the MIPS datapath.
//   - store/load access size encodings (also used by the load-side extension logic)
//   - state type of the store serializer
//   - byte_count(): number of bytes moved by an access of a given size
package mips_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RESP = 2'd2
  } ser_state_e;

  // Returns 0 for the illegal encoding so callers can never mistake it for a
  // real transfer length.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/store_serializer.sv
// store_serializer: splits one sb/sh/sw store into big-endian byte writes on an
// 8-bit memory port, one byte per accepted handshake, and reports completion
// (done) with an alignment/size error flag (err).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  store request handshake
//   req_addr/data/size   byte address, register value, access size
//   mem_valid/mem_ready  byte write handshake
//   mem_addr/mem_wdata   byte write address and data
//   done                 one-cycle completion pulse
//   err                  qualified by done; request rejected, nothing written
// All outputs come straight from flops.
module store_serializer
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              done,
  output logic              err
);

  ser_state_e        state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [2:0]        n_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              cap;
  logic              bad_req;

  logic              req_ready_q, req_ready_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Byte k of the low n bytes of d, most significant first.
  function automatic logic [7:0] lane_byte(input logic [31:0] d,
                                           input logic [2:0]  n,
                                           input logic [1:0]  k);
    logic [2:0] sel;
    sel = n - 3'd1 - {1'b0, k};
    case (sel)
      3'd0:    return d[7:0];
      3'd1:    return d[15:8];
      3'd2:    return d[23:16];
      default: return d[31:24];
    endcase
  endfunction

  always_comb begin
    bad_req = (req_size == 2'b11) ||
              ((req_size == SIZE_HALF) && req_addr[0]) ||
              ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cap         = 1'b0;
    req_ready_d = 1'b0;
    mem_valid_d = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          cap         = 1'b1;
          req_ready_d = 1'b0;
          if (bad_req) begin
            state_d = ST_RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            // First byte is presented straight from the request inputs since
            // the capture registers only load on this same edge.
            state_d     = ST_SEND;
            k_d         = 2'd0;
            mem_valid_d = 1'b1;
            mem_addr_d  = req_addr;
            mem_wdata_d = lane_byte(req_data, byte_count(req_size), 2'd0);
          end
        end
      end
      ST_SEND: begin
        if (mem_ready) begin
          if ({1'b0, k_q} == n_q - 3'd1) begin
            state_d = ST_RESP;
            done_d  = 1'b1;
          end else begin
            k_d         = k_q + 2'd1;
            mem_valid_d = 1'b1;
            mem_addr_d  = addr_q + ADDR_W'(k_d);
            mem_wdata_d = lane_byte(data_q, n_q, k_d);
          end
        end else begin
          mem_valid_d = 1'b1;
          mem_addr_d  = mem_addr_q;
          mem_wdata_d = mem_wdata_q;
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= 2'd0;
      req_ready_q <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      req_ready_q <= req_ready_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Request capture: pure data, qualified by state, so no reset needed.
  always_ff @(posedge clk) begin
    if (cap) begin
      addr_q <= req_addr;
      data_q <= req_data;
      n_q    <= byte_count(req_size);
    end
  end

  assign req_ready = req_ready_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_store_serializer.sv
// Testbench for store_serializer: directed cases with literal expectations plus
// randomized stores checked against a queue-based model of the byte stream.
module tb_store_serializer;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              done;
  logic              err;

  store_serializer #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  wr_t wlog[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  bit  exp_err = 1'b0;
  bit  outstanding = 1'b0;
  bit  last_err = 1'b0;
  int  wr_idx = 0;
  int  stalls = 0;
  int  rdy_mode = 0;
  int  stall_left = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference: which requests are rejected and which bytes a legal one writes.
  function automatic bit model_bad(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0);
  endfunction

  task automatic model_push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int n;
    wr_t w;
    exp_err = model_bad(a, s);
    if (!exp_err) begin
      n = 1 << s;
      for (int i = 0; i < n; i++) begin
        w.a = a + i;
        w.d = 8'((d >> (8 * (n - 1 - i))) & 32'hFF);
        exp_q.push_back(w);
      end
    end
  endtask

  // Monitor: drives mem_ready for the coming edge, then checks this cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      case (rdy_mode)
        0: mem_ready = 1'b1;
        1: mem_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (mem_valid && wr_idx == 1 && stall_left > 0) begin
            mem_ready = 1'b0;
            stall_left--;
          end else begin
            mem_ready = 1'b1;
          end
        end
      endcase
      if (mon_en) begin
        if (mem_valid) begin
          chk("ready_low_in_send", 64'(req_ready), 64'd0);
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            chk("wr_addr", 64'(mem_addr), 64'(exp_q[0].a));
            chk("wr_data", 64'(mem_wdata), 64'(exp_q[0].d));
            if (mem_ready) begin
              wlog.push_back('{mem_addr, mem_wdata});
              void'(exp_q.pop_front());
              wr_idx++;
            end else begin
              stalls++;
            end
          end
        end
        if (done) begin
          chk("done_expected", 64'(outstanding), 64'd1);
          chk("err", 64'(err), 64'(exp_err));
          chk("bytes_left", 64'(exp_q.size()), 64'd0);
          chk("ready_low_in_done", 64'(req_ready), 64'd0);
          chk("no_write_with_done", 64'(mem_valid), 64'd0);
          last_err = err;
          outstanding = 1'b0;
        end
      end
    end
  end

  // Issues one request starting just after a negedge; returns after the
  // done cycle plus one (or right after acceptance if wait_done is 0).
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                        input bit wait_done, output int lat);
    int budget;
    bit bad;
    lat = 0;
    budget = 0;
    while (!req_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 64'd0, 64'd1);
      return;
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    @(posedge clk);
    bad = model_bad(a, s);
    model_push(a, d, s);
    outstanding = 1'b1;
    wr_idx = 0;
    stalls = 0;
    #1;
    req_valid = 1'b0;
    req_data  = $urandom;
    req_addr  = $urandom;
    req_size  = 2'($urandom);
    if (!wait_done) return;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 200);
    if (!done) begin
      chk("done_timeout", 64'd0, 64'd1);
      return;
    end
    chk("latency", 64'(lat), bad ? 64'd1 : 64'((1 << s) + 1 + stalls));
    @(negedge clk);
    chk("ready_after_done", 64'(req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] sw_bytes [4];
    logic [31:0] ra;
    logic [1:0]  rs;
    sw_bytes = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};

    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    req_data = '0;
    req_size = '0;
    mem_ready = 1'b1;
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // sb
    wlog.delete();
    do_req(32'h1003, 32'hDEADBEEF, 2'b00, 1'b1, lat);
    chk("sb_lat", 64'(lat), 64'd2);
    chk("sb_count", 64'(wlog.size()), 64'd1);
    if (wlog.size() == 1) begin
      chk("sb_addr", 64'(wlog[0].a), 64'h1003);
      chk("sb_data", 64'(wlog[0].d), 64'hEF);
    end
    chk("sb_err", 64'(last_err), 64'd0);

    // sh
    wlog.delete();
    do_req(32'h2002, 32'h12345678, 2'b01, 1'b1, lat);
    chk("sh_lat", 64'(lat), 64'd3);
    chk("sh_count", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      chk("sh_addr0", 64'(wlog[0].a), 64'h2002);
      chk("sh_data0", 64'(wlog[0].d), 64'h56);
      chk("sh_addr1", 64'(wlog[1].a), 64'h2003);
      chk("sh_data1", 64'(wlog[1].d), 64'h78);
    end

    // sw with a 3-cycle stall on the second byte
    wlog.delete();
    rdy_mode = 2;
    stall_left = 3;
    do_req(32'h3000, 32'hCAFEF00D, 2'b10, 1'b1, lat);
    chk("sw_lat", 64'(lat), 64'd8);
    chk("sw_count", 64'(wlog.size()), 64'd4);
    if (wlog.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("sw_addr", 64'(wlog[i].a), 64'(32'h3000 + i));
        chk("sw_data", 64'(wlog[i].d), 64'(sw_bytes[i]));
      end
    end
    rdy_mode = 0;

    // rejected requests
    wlog.delete();
    do_req(32'h2001, 32'h11111111, 2'b01, 1'b1, lat);
    chk("err_sh_lat", 64'(lat), 64'd1);
    chk("err_sh_flag", 64'(last_err), 64'd1);
    do_req(32'h3002, 32'h22222222, 2'b10, 1'b1, lat);
    chk("err_sw_lat", 64'(lat), 64'd1);
    chk("err_sw_flag", 64'(last_err), 64'd1);
    do_req(32'h4000, 32'h33333333, 2'b11, 1'b1, lat);
    chk("err_sz_lat", 64'(lat), 64'd1);
    chk("err_sz_flag", 64'(last_err), 64'd1);
    chk("err_no_writes", 64'(wlog.size()), 64'd0);

    // reset during the third byte of a word store
    do_req(32'h5000, 32'h11223344, 2'b10, 1'b0, lat);
    lat = 0;
    while (!(mem_valid && mem_addr == 32'h5002) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("reach_third_byte", 64'(mem_valid && mem_addr == 32'h5002), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_valid", 64'(mem_valid), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
    exp_q.delete();
    outstanding = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'd1);
    chk("post_rst_no_done", 64'(done), 64'd0);
    wlog.delete();
    do_req(32'h6001, 32'hA5A5A5C3, 2'b00, 1'b1, lat);
    chk("post_rst_sb_lat", 64'(lat), 64'd2);
    chk("post_rst_sb_count", 64'(wlog.size()), 64'd1);
    if (wlog.size() == 1) chk("post_rst_sb_data", 64'(wlog[0].d), 64'hC3);

    // randomized stores with random mem_ready back-pressure
    rdy_mode = 1;
    for (int it = 0; it < 60; it++) begin
      ra = $urandom;
      if ($urandom_range(0, 2) != 0) ra[1:0] = 2'b00;
      rs = 2'($urandom_range(0, 3));
      do_req(ra, $urandom, rs, 1'b1, lat);
    end
    rdy_mode = 0;

    repeat (3) @(negedge clk);
    chk("final_idle_ready", 64'(req_ready), 64'd1);
    chk("final_no_pending", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
